// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a 16-bit little-endian word count,
// assembles little-endian words from a byte stream and holds the core in reset until done.
module imem_loader #(
    parameter int unsigned WORDS = 64,
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [WIDTH-3:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic               done,
    output logic               error,
    output logic               core_rst_n
);

    localparam int unsigned BYTES  = WIDTH / 8;
    localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned ADDR_W = WIDTH - 2;
    localparam int unsigned CNT_W  = 16;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [CNT_W:0]   WORDS_L  = (CNT_W + 1)'(WORDS);

    localparam logic [1:0] S_LEN0 = 2'd0;
    localparam logic [1:0] S_LEN1 = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_wcnt;
    logic [IDX_W-1:0]  r_idx;
    logic [WIDTH-1:0]  r_buf;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_done;
    logic              r_error;
    logic              r_core_rst_n;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_wcnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [WIDTH-1:0]  w_buf_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [WIDTH-1:0]  w_wdata_nxt;
    logic              w_done_nxt;
    logic              w_error_nxt;
    logic              w_core_rst_n_nxt;

    logic              w_xfer;
    logic [WIDTH-1:0]  w_word;
    logic [CNT_W-1:0]  w_cnt_full;
    logic [CNT_W-1:0]  w_wcnt_inc;
    logic              w_in_range;

    // Ready is the only combinational output: it must drop while rst_n is held low.
    assign in_ready = rst_n && (r_state != S_DONE);
    assign w_xfer   = in_valid && in_ready;

    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign done       = r_done;
    assign error      = r_error;
    assign core_rst_n = r_core_rst_n;

    // Next-state and datapath decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_wcnt_nxt       = r_wcnt;
        w_idx_nxt        = r_idx;
        w_buf_nxt        = r_buf;
        w_we_nxt         = 1'b0;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_done_nxt       = r_done;
        w_error_nxt      = r_error;
        w_core_rst_n_nxt = r_core_rst_n;

        w_cnt_full = {in_data, r_count[7:0]};
        w_wcnt_inc = r_wcnt + 16'd1;
        w_in_range = ({1'b0, r_wcnt} < WORDS_L);

        w_word = r_buf;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (r_idx == IDX_W'(b)) begin
                w_word[b*8 +: 8] = in_data;
            end
        end

        case (r_state)
            S_LEN0: begin
                if (w_xfer) begin
                    w_count_nxt[7:0] = in_data;
                    w_state_nxt      = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_xfer) begin
                    w_count_nxt = w_cnt_full;
                    w_idx_nxt   = '0;
                    w_wcnt_nxt  = '0;
                    if ({1'b0, w_cnt_full} > WORDS_L) begin
                        w_error_nxt = 1'b1;
                    end
                    if (w_cnt_full == '0) begin
                        w_state_nxt      = S_DONE;
                        w_done_nxt       = 1'b1;
                        w_core_rst_n_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_buf_nxt = w_word;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt  = '0;
                        w_wcnt_nxt = w_wcnt_inc;
                        // Out-of-range words are consumed but never reach memory.
                        if (w_in_range) begin
                            w_we_nxt    = 1'b1;
                            w_addr_nxt  = ADDR_W'(r_wcnt);
                            w_wdata_nxt = w_word;
                        end
                        if (w_wcnt_inc == r_count) begin
                            w_state_nxt      = S_DONE;
                            w_done_nxt       = 1'b1;
                            w_core_rst_n_nxt = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt      = S_LEN0;
                    w_count_nxt      = '0;
                    w_done_nxt       = 1'b0;
                    w_core_rst_n_nxt = 1'b0;
                    w_error_nxt      = 1'b0;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_LEN0;
            r_count      <= '0;
            r_wcnt       <= '0;
            r_idx        <= '0;
            r_buf        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_idx        <= w_idx_nxt;
            r_buf        <= w_buf_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_core_rst_n <= w_core_rst_n_nxt;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus hand-written
// sequences for gaps, mid-load reset, overflow and restart.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        error;
    logic        core_rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    imem_loader #(.WORDS(64), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .error     (error),
        .core_rst_n(core_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        vld;
        logic [7:0]  data;
        logic        e_rdy;
        logic        e_we;
        logic [29:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_done;
        logic        e_err;
        logic        e_crst;
    } vec_t;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  wq[$];
    wr_t  exp_q[$];

    // Record every write pulse seen on the memory port.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back('{a: mem_addr, d: mem_wdata});
    end

    function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] d, logic rdy, logic we,
                                logic [29:0] a, logic [31:0] wd, logic dn, logic er, logic cr);
        vec_t t;
        t = '{rst_n: r, start: s, vld: v, data: d, e_rdy: rdy, e_we: we, e_addr: a,
              e_wdata: wd, e_done: dn, e_err: er, e_crst: cr};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h00;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [31:0] t;
        t = w;
        for (int b = 0; b < 4; b++) begin
            send_byte(t[7:0], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            t = t >> 8;
        end
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".crst"}, 32'(core_rst_n), 32'd0);
        chk({tag, ".err"},  32'(error), 32'd0);
        chk({tag, ".rdy"},  32'(in_ready), 32'd1);
        wq.delete();
    endtask

    task automatic settle_and_compare(input string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".nwr"}, 32'(wq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), 32'(wq[i].a), 32'(exp_q[i].a));
            chk($sformatf("%s.data%0d", tag, i), wq[i].d, exp_q[i].d);
        end
    endtask

    initial begin
        logic [31:0] gw [3];
        logic [7:0]  k8;

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // rst  st  v  data   rdy we addr  wdata        done err crst
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 30'd0, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h02, 1, 0, 30'd0, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 30'd0, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h55, 1, 0, 30'd0, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h13, 1, 0, 30'd0, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 30'd0, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 30'd0, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h00, 1, 1, 30'd0, 32'h0000_0013, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h6F, 1, 0, 30'd0, 32'h0000_0013, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 30'd0, 32'h0000_0013, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 30'd0, 32'h0000_0013, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 0, 1, 30'd1, 32'h0000_006F, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 8'h99, 0, 0, 30'd1, 32'h0000_006F, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h00, 1, 0, 30'd1, 32'h0000_006F, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 30'd1, 32'h0000_006F, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 0, 0, 30'd1, 32'h0000_006F, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 30'd1, 32'h0000_006F, 1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n    = vecs[i].rst_n;
            start    = vecs[i].start;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d.rdy", i),   32'(in_ready),   32'(vecs[i].e_rdy));
            chk($sformatf("row%0d.we", i),    32'(mem_we),     32'(vecs[i].e_we));
            chk($sformatf("row%0d.addr", i),  32'(mem_addr),   32'(vecs[i].e_addr));
            chk($sformatf("row%0d.wdata", i), mem_wdata,       vecs[i].e_wdata);
            chk($sformatf("row%0d.done", i),  32'(done),       32'(vecs[i].e_done));
            chk($sformatf("row%0d.err", i),   32'(error),      32'(vecs[i].e_err));
            chk($sformatf("row%0d.crst", i),  32'(core_rst_n), 32'(vecs[i].e_crst));
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Three-word load with random idle gaps between bytes.
        pulse_start("gap.start");
        gw[0] = 32'h1122_3344;
        gw[1] = 32'hA5A5_0F0F;
        gw[2] = 32'h00C0_FFEE;
        exp_q.delete();
        send_byte(8'h03, int'($urandom_range(0, 5)));
        send_byte(8'h00, int'($urandom_range(0, 5)));
        for (int w = 0; w < 3; w++) begin
            send_word(gw[w], 5);
            exp_q.push_back('{a: 30'(w), d: gw[w]});
        end
        chk("gap.done", 32'(done), 32'd1);
        settle_and_compare("gap");

        // Reset after header plus one word of a two-word load.
        pulse_start("rst.start");
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h0403_0201, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.rdy",   32'(in_ready), 32'd0);
        chk("rst.we",    32'(mem_we), 32'd0);
        chk("rst.addr",  32'(mem_addr), 32'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        chk("rst.done",  32'(done), 32'd0);
        chk("rst.crst",  32'(core_rst_n), 32'd0);
        rst_n = 1'b1;
        wq.delete();
        exp_q.delete();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hDDCC_BBAA, 0);
        exp_q.push_back('{a: 30'd0, d: 32'hDDCC_BBAA});
        chk("rst.done2", 32'(done), 32'd1);
        settle_and_compare("rst");

        // Header of 65 words against a 64-word memory.
        pulse_start("ovf.start");
        exp_q.delete();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        chk("ovf.err_hdr", 32'(error), 32'd1);
        chk("ovf.rdy_hdr", 32'(in_ready), 32'd1);
        for (int k = 0; k < 65; k++) begin
            k8 = 8'(k);
            if (k == 64) chk("ovf.done_before", 32'(done), 32'd0);
            send_word({~k8, 8'hC3, 8'h5A, k8}, 0);
            if (k < 64) exp_q.push_back('{a: 30'(k), d: {~k8, 8'hC3, 8'h5A, k8}});
        end
        chk("ovf.done", 32'(done), 32'd1);
        chk("ovf.crst", 32'(core_rst_n), 32'd1);
        chk("ovf.rdy",  32'(in_ready), 32'd0);
        chk("ovf.we_last", 32'(mem_we), 32'd0);
        settle_and_compare("ovf");

        // Restart from DONE clears the sticky error.
        pulse_start("re.start");
        exp_q.delete();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hDEAD_BEEF, 0);
        exp_q.push_back('{a: 30'd0, d: 32'hDEAD_BEEF});
        chk("re.done", 32'(done), 32'd1);
        chk("re.err",  32'(error), 32'd0);
        settle_and_compare("re");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the SoC instruction memory; the write-side counterpart of the combinational instruction-fetch read port.
- Accepts a byte stream over a valid/ready interface, typically from a UART receiver. Parses a 16-bit word-count header, assembles little-endian words and issues single-cycle writes to instruction memory.
- Holds the core in reset until loading completes.

Parameters:
- WORDS, 64, instruction memory depth in words; writes beyond it are discarded.
- WIDTH, 32, word width in bits; must be a multiple of 8. BYTES = WIDTH/8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: re-arm loader from DONE
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts byte (transfer = in_valid & in_ready)
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  WIDTH-2  word address of write (same word addressing as fetch port)
- mem_wdata  out  WIDTH  word to write
- done  out  1  load complete
- error  out  1  sticky: header count exceeded WORDS
- core_rst_n  out  1  core reset, active-low; released only in DONE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=LEN0; byte index, word counter, address, count and error cleared.
  - mem_we=0, mem_addr=0, mem_wdata=0, done=0, core_rst_n=0.
  - in_ready=0 while rst_n is low.
- Reset mid-load aborts the load. Words already written stay in memory; the loader restarts at LEN0.
- States and transitions (all on transfer unless noted):
  - LEN0: latch count[7:0] -> LEN1.
  - LEN1: latch count[15:8]. If count==0 -> DONE; else -> DATA.
  - DATA: shift byte into word buffer at position byte_idx (byte 0 = bits 7:0, little-endian).
    - On the byte with byte_idx==BYTES-1: register the write (see below), byte_idx wraps to 0, word counter +1.
    - When the word counter reaches count -> DONE.
  - DONE: in_ready=0, done=1, core_rst_n=1. On start -> LEN0, with done=0, core_rst_n=0 and error cleared in the same edge.
- start is ignored in states other than DONE.
- in_ready=1 in LEN0, LEN1 and DATA (rst_n high). The block never back-pressures mid-load because memory writes are single-cycle.
- Write timing, latency 1:
  - mem_we=1 the cycle after the final byte of a word is accepted.
  - mem_addr = word index (0,1,2,...); mem_wdata = assembled word.
  - mem_we is high for exactly one cycle per word; otherwise mem_we=0.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- Overflow:
  - If count > WORDS, error is set when LEN1 completes.
  - Words with index >= WORDS are consumed but produce no mem_we.
  - The loader still consumes all count words before entering DONE.
- The final word's write (mem_we) occurs in the same cycle DONE is entered. core_rst_n rises on that same edge, so the write lands before the core fetches.
- Transfers with in_valid=0 do not advance any state. Gaps between bytes of any length are allowed.
- count is a 16-bit unsigned value; the word counter is 16 bits and does not wrap.

Test Plan:
- Reset then stream 02 00 | 13 00 00 00 | 6F 00 00 00 -> mem_we pulses at addr 0 data 0x00000013, then addr 1 data 0x0000006F. done=1, core_rst_n=1 after the last write, in_ready=0, error=0.
- Header 00 00 -> DONE directly after the second byte. No mem_we, done=1, error=0.
- Header 41 00 (65 words) with WORDS=64, 260 data bytes -> error=1 after the header; 64 writes at addr 0..63 and no write for word 64; done=1 after byte 262.
- Random in_valid gaps (0–5 idle cycles between bytes) on a 3-word load -> same writes and data as a gap-free run; no extra mem_we pulses.
- rst_n low for 1 cycle after 6 bytes of a 2-word load -> outputs return to reset values. A fresh 01 00 AA BB CC DD load writes 0xDDCCBBAA to addr 0.
- In DONE, pulse start and reload 01 00 EF BE AD DE -> done and core_rst_n drop on the start edge, error cleared; a single write of 0xDEADBEEF to addr 0; done=1 again.
